// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a dual-SRAM access block.
// Each grant runs one memory transaction and ends in a single ack or timeout err pulse.
module ram_arbiter #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [16:0] p0_addr,
    input  logic [15:0] p0_wdata,
    output logic        p0_ack,
    output logic        p0_err,
    output logic [15:0] p0_rdata,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [16:0] p1_addr,
    input  logic [15:0] p1_wdata,
    output logic        p1_ack,
    output logic        p1_err,
    output logic [15:0] p1_rdata,
    output logic        mem_en,
    output logic        mem_re,
    output logic        mem_we,
    output logic [16:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_done,
    input  logic [15:0] mem_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        win_q, win_d;
    logic        last_q, last_d;
    logic        we_q, we_d;
    logic [16:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [15:0] rdata_q [2];
    logic [15:0] rdata_d [2];

    logic        resp_ok, resp_err;
    logic [1:0]  ack_w, err_w;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            win_q      <= 1'b0;
            last_q     <= 1'b1;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            rdata_q[0] <= '0;
            rdata_q[1] <= '0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            last_q     <= last_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            rdata_q[0] <= rdata_d[0];
            rdata_q[1] <= rdata_d[1];
        end
    end

    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        last_d     = last_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        rdata_d[0] = rdata_q[0];
        rdata_d[1] = rdata_q[1];
        case (state_q)
            ST_IDLE: begin
                if (p0_req || p1_req) begin
                    // Contention goes to the port not granted last; a lone requester always wins.
                    win_d   = (p0_req && p1_req) ? ~last_q : p1_req;
                    last_d  = win_d;
                    we_d    = win_d ? p1_we    : p0_we;
                    addr_d  = win_d ? p1_addr  : p0_addr;
                    wdata_d = win_d ? p1_wdata : p0_wdata;
                    cnt_d   = '0;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (mem_done) begin
                    err_d = 1'b0;
                    if (!we_q) begin
                        rdata_d[win_q] = mem_rdata;
                    end
                    state_d = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        mem_en    = (state_q == ST_ACCESS);
        mem_re    = (state_q == ST_ACCESS) && !we_q;
        mem_we    = (state_q == ST_ACCESS) && we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        busy      = (state_q != ST_IDLE);
        resp_ok   = (state_q == ST_RESP) && !err_q;
        resp_err  = (state_q == ST_RESP) && err_q;
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            assign ack_w[gi] = resp_ok  && (win_q == 1'(gi));
            assign err_w[gi] = resp_err && (win_q == 1'(gi));
        end
    endgenerate

    assign p0_ack   = ack_w[0];
    assign p0_err   = err_w[0];
    assign p1_ack   = ack_w[1];
    assign p1_err   = err_w[1];
    assign p0_rdata = rdata_q[0];
    assign p1_rdata = rdata_q[1];

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed table, multi-cycle corner sequences,
// then random transactions predicted by a transaction-level arbitration model.
module tb_ram_arbiter;

    localparam int TO = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [16:0] p0_addr, p1_addr;
    logic [15:0] p0_wdata, p1_wdata;
    logic        p0_ack, p0_err, p1_ack, p1_err;
    logic [15:0] p0_rdata, p1_rdata;
    logic        mem_en, mem_re, mem_we, mem_done, busy;
    logic [16:0] mem_addr;
    logic [15:0] mem_wdata, mem_rdata;
    logic [3:0]  resp_vec;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign resp_vec = {p0_ack, p0_err, p1_ack, p1_err};

    ram_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
        .mem_en(mem_en), .mem_re(mem_re), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_done(mem_done), .mem_rdata(mem_rdata), .busy(busy)
    );

    typedef struct {
        logic        r0, r1, we0, we1;
        logic [16:0] a0, a1;
        logic [15:0] w0, w1;
        int          d;
        logic [15:0] rd;
        logic [3:0]  vec;
        logic [16:0] eaddr;
        logic        ewe;
        logic [15:0] ewd;
        int          cyc;
        logic [15:0] erd0, erd1;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one granted transaction: mem_done arrives in ACCESS cycle d (never if d >= TO).
    task automatic serve(input int d, input logic [15:0] rd, input logic [3:0] evec,
                         input logic [16:0] eaddr, input logic ewe, input logic [15:0] ewd,
                         input int ecyc, input logic [15:0] erd0, input logic [15:0] erd1);
        int waited;
        int cyc;
        waited = 1;
        cyc    = 0;
        tick();
        while (!mem_en && waited < 5) begin
            tick();
            waited++;
        end
        chk("grant_latency", waited, 1);
        if (!mem_en) return;
        while (mem_en && cyc < TO + 4) begin
            chk("access_addr", mem_addr, eaddr);
            chk("access_we_re", {mem_we, mem_re}, {ewe, ~ewe});
            chk("access_wdata", mem_wdata, ewd);
            chk("access_busy", busy, 1);
            chk("access_no_pulse", resp_vec, 0);
            mem_done  = (cyc == d);
            mem_rdata = (cyc == d) ? rd : 16'($urandom);
            cyc++;
            tick();
        end
        chk("access_cycles", cyc, ecyc);
        mem_done  = 1'($urandom_range(0, 1));
        mem_rdata = 16'($urandom);
        chk("resp_pulse", resp_vec, evec);
        chk("resp_busy", busy, 1);
        chk("resp_mem_en", {mem_en, mem_re, mem_we}, 0);
        if (evec[3] || evec[2]) p0_req = 1'b0;
        if (evec[1] || evec[0]) p1_req = 1'b0;
        tick();
        mem_done = 1'b0;
        $display("txn vec=%b addr=%h we=%b cyc=%0d rdata0=%h rdata1=%h", evec, eaddr, ewe, cyc, p0_rdata, p1_rdata);
        chk("idle_pulse", resp_vec, 0);
        chk("idle_busy", busy, 0);
        chk("rdata0", p0_rdata, erd0);
        chk("rdata1", p1_rdata, erd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl [9];
        logic        m_last, win, ok, pend0, pend1;
        logic [15:0] m_rd0, m_rd1, rd;
        logic [3:0]  evec;
        logic [1:0]  s;
        int          d;

        tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 17'h00020, 17'h10020, 16'h0, 16'h0, 1, 16'h1111,
                   4'b1000, 17'h00020, 1'b0, 16'h0000, 2, 16'h1111, 16'h0000};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 17'h00020, 17'h10020, 16'h0, 16'h0, 0, 16'h2222,
                   4'b0010, 17'h10020, 1'b0, 16'h0000, 1, 16'h1111, 16'h2222};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 17'h00010, 17'h10020, 16'h0, 16'h0, 0, 16'hBEEF,
                   4'b1000, 17'h00010, 1'b0, 16'h0000, 1, 16'hBEEF, 16'h2222};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 17'h00010, 17'h10005, 16'h0, 16'h1234, 99, 16'h0000,
                   4'b0001, 17'h10005, 1'b1, 16'h1234, TO, 16'hBEEF, 16'h2222};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 17'h000FF, 17'h10005, 16'hABCD, 16'h0, TO - 1, 16'hDEAD,
                   4'b1000, 17'h000FF, 1'b1, 16'hABCD, TO, 16'hBEEF, 16'h2222};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 17'h000FF, 17'h10100, 16'h0, 16'h0, TO - 1, 16'h5A5A,
                   4'b0010, 17'h10100, 1'b0, 16'h0000, TO, 16'hBEEF, 16'h5A5A};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 17'h00066, 17'h10100, 16'h0, 16'h0, TO, 16'h6666,
                   4'b0100, 17'h00066, 1'b0, 16'h0000, TO, 16'hBEEF, 16'h5A5A};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 17'h00033, 17'h10044, 16'h0, 16'h0, 2, 16'h7777,
                   4'b0010, 17'h10044, 1'b0, 16'h0000, 3, 16'hBEEF, 16'h7777};
        tbl[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 17'h00033, 17'h10044, 16'h0, 16'h0, 0, 16'h8888,
                   4'b1000, 17'h00033, 1'b0, 16'h0000, 1, 16'h8888, 16'h7777};

        rst = 1'b1;
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
        mem_done = 1'b0; mem_rdata = '0;
        tick();
        tick();
        chk("reset_busy", busy, 0);
        chk("reset_mem", {mem_en, mem_re, mem_we}, 0);
        chk("reset_mem_addr", mem_addr, 0);
        chk("reset_mem_wdata", mem_wdata, 0);
        chk("reset_pulses", resp_vec, 0);
        chk("reset_rdata", {p0_rdata, p1_rdata}, 0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            p0_req = tbl[i].r0; p0_we = tbl[i].we0; p0_addr = tbl[i].a0; p0_wdata = tbl[i].w0;
            p1_req = tbl[i].r1; p1_we = tbl[i].we1; p1_addr = tbl[i].a1; p1_wdata = tbl[i].w1;
            serve(tbl[i].d, tbl[i].rd, tbl[i].vec, tbl[i].eaddr, tbl[i].ewe, tbl[i].ewd,
                  tbl[i].cyc, tbl[i].erd0, tbl[i].erd1);
        end

        // Reset in the middle of ACCESS discards the transaction and clears read data.
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 17'h00042;
        tick();
        chk("rst_seq_access", mem_en, 1);
        tick();
        rst = 1'b1;
        p0_req = 1'b0;
        tick();
        rst = 1'b0;
        chk("rst_seq_idle", {mem_en, busy}, 0);
        chk("rst_seq_pulse", resp_vec, 0);
        mem_done = 1'b1;
        mem_rdata = 16'hFFFF;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rst_seq_late_done", {resp_vec, mem_en, busy}, 0);
        end
        mem_done = 1'b0;
        chk("rst_seq_rdata", {p0_rdata, p1_rdata}, 0);
        $display("txn reset-mid-access rdata0=%h rdata1=%h", p0_rdata, p1_rdata);

        // Held request: back-to-back reads with one IDLE cycle; mem_done in IDLE is ignored.
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 17'h00077;
        mem_done = 1'b1;
        mem_rdata = 16'hCAFE;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("b2b_mem_en", mem_en, (i == 0 || i == 3) ? 1 : 0);
            chk("b2b_pulse", resp_vec, (i == 1 || i == 4) ? 4'b1000 : 4'b0000);
            chk("b2b_busy", busy, (i == 2 || i == 5) ? 0 : 1);
            if (i == 4) p0_req = 1'b0;
        end
        mem_done = 1'b0;
        chk("b2b_rdata", p0_rdata, 16'hCAFE);
        $display("txn back-to-back rdata0=%h", p0_rdata);

        m_last = 1'b0;
        m_rd0  = 16'hCAFE;
        m_rd1  = 16'h0000;
        for (int t = 0; t < 40; t++) begin
            s = 2'($urandom_range(1, 3));
            pend0 = s[0];
            pend1 = s[1];
            p0_we = 1'($urandom); p0_addr = 17'($urandom); p0_wdata = 16'($urandom);
            p1_we = 1'($urandom); p1_addr = 17'($urandom); p1_wdata = 16'($urandom);
            p0_req = pend0;
            p1_req = pend1;
            while (pend0 || pend1) begin
                win = (pend0 && pend1) ? ~m_last : pend1;
                d   = $urandom_range(0, TO + 1);
                rd  = 16'($urandom);
                ok  = (d < TO);
                evec = win ? (ok ? 4'b0010 : 4'b0001) : (ok ? 4'b1000 : 4'b0100);
                if (ok && !(win ? p1_we : p0_we)) begin
                    if (win) m_rd1 = rd;
                    else     m_rd0 = rd;
                end
                m_last = win;
                if (win) pend1 = 1'b0;
                else     pend0 = 1'b0;
                serve(d, rd, evec, win ? p1_addr : p0_addr, win ? p1_we : p0_we,
                      win ? p1_wdata : p0_wdata, ok ? d + 1 : TO, m_rd0, m_rd1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 15, ACCESS cycles without mem_done before a transaction is aborted (legal range 1..255).
REQ-002 clk  input  1  single clock; all logic updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 p0_req / p1_req  input  1  port request; held high until that port's ack or err.
REQ-005 p0_we / p1_we  input  1  1 = write, 0 = read; valid while req is high.
REQ-006 p0_addr / p1_addr  input  17  word address; bit 16 selects RAM1 (0) or RAM2 (1) downstream.
REQ-007 p0_wdata / p1_wdata  input  16  write data.
REQ-008 p0_ack / p1_ack  output  1  one-cycle completion pulse.
REQ-009 p0_err / p1_err  output  1  one-cycle timeout pulse; replaces ack for that transaction.
REQ-010 p0_rdata / p1_rdata  output  16  read data, registered, held until that port's next completion.
REQ-011 mem_en, mem_re, mem_we  output  1 each  strobes to the dual-SRAM access block.
REQ-012 mem_addr  output  17; mem_wdata  output  16  latched transaction address and data.
REQ-013 mem_done  input  1; mem_rdata  input  16  completion and read data from the dual-SRAM access block.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 FSM states: IDLE, ACCESS, RESP; encoding is free.
REQ-016 IDLE: when either req is sampled high, latch winner id, we, addr and wdata into registers, clear the timeout counter, and go to ACCESS.
REQ-017 Arbitration is round-robin: if only one port requests, it wins; if both request, the port not granted last wins; the last-grant register updates on every grant.
REQ-018 ACCESS: mem_en=1, mem_we=latched we, mem_re=~latched we; mem_addr and mem_wdata come from the latched registers and stay stable for the whole state.
REQ-019 ACCESS: if mem_done is sampled high, capture mem_rdata (reads only) into the winner's rdata register and go to RESP with status OK.
REQ-020 ACCESS: the timeout counter increments each cycle without mem_done; when it reaches TIMEOUT-1 with no mem_done, go to RESP with status ERR; mem_done on that same edge wins over the timeout.
REQ-021 RESP: mem_en/mem_re/mem_we=0; the winner sees ack=1 (OK) or err=1 (ERR) for exactly one cycle; the other port sees 0; then go to IDLE.
REQ-022 On ERR, the winner's rdata is not modified.
REQ-023 Minimum latency: req sampled at edge k, ACCESS in cycle k..k+1, mem_done high in the first ACCESS cycle gives ack high in the cycle after edge k+1 (2 edges).
REQ-024 A request is not re-evaluated in RESP; a req still high in the first IDLE cycle after RESP is treated as a new request.
REQ-025 Dropping req during ACCESS does not abort the transaction; ack or err is still issued.
REQ-026 mem_done is ignored in IDLE and RESP.
REQ-027 A write completion leaves the winner's rdata unchanged.
REQ-028 At most one of {p0_ack, p0_err, p1_ack, p1_err} is high in any cycle.

Reset
REQ-029 rst high at an edge forces IDLE regardless of state, including mid-ACCESS; the pending transaction is discarded with no ack or err.
REQ-030 Reset values: all mem_* outputs 0, all ack/err 0, both rdata 16'h0000, busy 0, timeout counter 0, last-grant = port 1 (so port 0 wins the first contention).

Verification
REQ-031 p0 read at addr 17'h00010, mem_done one cycle into ACCESS with mem_rdata=16'hBEEF -> mem_re=1, mem_addr=17'h00010; p0_ack pulses 2 edges after req; p0_rdata=16'hBEEF.
REQ-032 p0 and p1 request in the same cycle after reset, then again -> first grant p0, second p1; p1 waits with req high and gets exactly one ack.
REQ-033 p1 write at addr 17'h10005, data 16'h1234, mem_done held low -> mem_we=1 for exactly TIMEOUT cycles; p1_err pulses once; p1_ack stays 0; p1_rdata unchanged.
REQ-034 rst asserted during ACCESS of a p0 read -> next cycle IDLE, mem_en=0, busy=0; no p0_ack or p0_err; later mem_done has no effect.
REQ-035 p0 holds req through ack while p1 idle -> back-to-back transactions with one IDLE cycle between them; mem_done pulses in IDLE are ignored.
